// File: rtl/term_cursor_ctrl.sv
// Terminal write engine: ASCII stream in, screen BRAM port A writes out.
// Tracks the cursor, scrolls by rotating row_offset, and clears with write bursts.
module term_cursor_ctrl #(
    parameter int SCREEN_ADDRESS_WIDTH  = 15,
    parameter int HORIZONTAL_SLOT_COUNT = 240,
    parameter int VERTICAL_SLOT_COUNT   = 135,
    parameter int COL_WIDTH             = 8,
    parameter int ROW_WIDTH             = 8,
    parameter logic [6:0] BLANK_CHAR    = 7'h20
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [6:0]                      in_data,
    output logic                            bram_wen,
    output logic [SCREEN_ADDRESS_WIDTH-1:0] bram_addr,
    output logic [6:0]                      bram_data,
    output logic [COL_WIDTH-1:0]            cursor_col,
    output logic [ROW_WIDTH-1:0]            cursor_row,
    output logic [ROW_WIDTH-1:0]            row_offset,
    output logic                            busy
);
    localparam int H  = HORIZONTAL_SLOT_COUNT;
    localparam int V  = VERTICAL_SLOT_COUNT;
    localparam int AW = SCREEN_ADDRESS_WIDTH;

    localparam logic [COL_WIDTH-1:0] LAST_COL     = COL_WIDTH'(H - 1);
    localparam logic [ROW_WIDTH-1:0] LAST_ROW     = ROW_WIDTH'(V - 1);
    localparam logic [AW-1:0]        LINE_CELLS   = AW'(H);
    localparam logic [AW-1:0]        SCREEN_CELLS = AW'(H * V);

    localparam logic [6:0] CH_BS = 7'h08;
    localparam logic [6:0] CH_LF = 7'h0A;
    localparam logic [6:0] CH_FF = 7'h0C;
    localparam logic [6:0] CH_CR = 7'h0D;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        NEWLINE,
        CLEAR_LINE,
        CLEAR_ALL
    } state_t;

    state_t         state;
    logic           nl_pend;
    logic           ff_pend;
    logic [AW-1:0]  clr_cnt;
    logic [AW-1:0]  clr_limit;
    logic           is_print;
    logic           at_last_row;
    logic [ROW_WIDTH-1:0] nl_row;
    logic [ROW_WIDTH-1:0] nl_off;

    // Logical row to physical row: one compare-subtract, no divider.
    function automatic logic [ROW_WIDTH-1:0] phys_row(
        input logic [ROW_WIDTH-1:0] r,
        input logic [ROW_WIDTH-1:0] o
    );
        logic [ROW_WIDTH:0] s;
        s = {1'b0, r} + {1'b0, o};
        if (s >= (ROW_WIDTH+1)'(V))
            s = s - (ROW_WIDTH+1)'(V);
        return s[ROW_WIDTH-1:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(
        input logic [COL_WIDTH-1:0] c,
        input logic [ROW_WIDTH-1:0] r,
        input logic [ROW_WIDTH-1:0] o
    );
        return AW'(phys_row(r, o)) * AW'(H) + AW'(c);
    endfunction

    assign in_ready    = (state == IDLE) && !rst;
    assign is_print    = (in_data >= 7'h20) && (in_data != 7'h7F);
    assign at_last_row = (cursor_row == LAST_ROW);
    assign nl_row      = at_last_row ? cursor_row : cursor_row + 1'b1;
    assign nl_off      = !at_last_row ? row_offset :
                         (row_offset == LAST_ROW) ? '0 : row_offset + 1'b1;
    assign clr_limit   = (state == CLEAR_LINE) ? LINE_CELLS : SCREEN_CELLS;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            nl_pend    <= 1'b0;
            ff_pend    <= 1'b0;
            clr_cnt    <= '0;
            bram_wen   <= 1'b0;
            bram_addr  <= '0;
            bram_data  <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
            row_offset <= '0;
            busy       <= 1'b0;
        end else begin
            bram_wen <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        unique case (1'b1)
                            is_print: begin
                                bram_wen  <= 1'b1;
                                bram_addr <= cell_addr(cursor_col, cursor_row, row_offset);
                                bram_data <= in_data;
                                if (cursor_col == LAST_COL)
                                    nl_pend <= 1'b1;
                                else
                                    cursor_col <= cursor_col + 1'b1;
                                state <= WRITE;
                            end
                            (in_data == CH_CR): begin
                                cursor_col <= '0;
                                state      <= WRITE;
                            end
                            (in_data == CH_LF): begin
                                nl_pend <= 1'b1;
                                state   <= WRITE;
                            end
                            (in_data == CH_BS): begin
                                if (cursor_col != '0) begin
                                    cursor_col <= cursor_col - 1'b1;
                                    bram_wen   <= 1'b1;
                                    bram_addr  <= cell_addr(cursor_col - 1'b1,
                                                            cursor_row, row_offset);
                                    bram_data  <= BLANK_CHAR;
                                end
                                state <= WRITE;
                            end
                            (in_data == CH_FF): begin
                                ff_pend <= 1'b1;
                                state   <= WRITE;
                            end
                            default: ;
                        endcase
                    end
                end
                WRITE: begin
                    nl_pend <= 1'b0;
                    ff_pend <= 1'b0;
                    if (nl_pend) begin
                        state <= NEWLINE;
                    end else if (ff_pend) begin
                        cursor_col <= '0;
                        cursor_row <= '0;
                        row_offset <= '0;
                        bram_wen   <= 1'b1;
                        bram_addr  <= '0;
                        bram_data  <= BLANK_CHAR;
                        clr_cnt    <= AW'(1);
                        busy       <= 1'b1;
                        state      <= CLEAR_ALL;
                    end else begin
                        state <= IDLE;
                    end
                end
                NEWLINE: begin
                    cursor_col <= '0;
                    cursor_row <= nl_row;
                    row_offset <= nl_off;
                    bram_wen   <= 1'b1;
                    bram_addr  <= cell_addr('0, nl_row, nl_off);
                    bram_data  <= BLANK_CHAR;
                    clr_cnt    <= AW'(1);
                    busy       <= 1'b1;
                    state      <= CLEAR_LINE;
                end
                CLEAR_LINE, CLEAR_ALL: begin
                    // A cleared line is physically contiguous, so both bursts just step the address.
                    if (clr_cnt == clr_limit) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        bram_wen  <= 1'b1;
                        bram_addr <= bram_addr + 1'b1;
                        clr_cnt   <= clr_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_term_cursor_ctrl.sv
// Bench for term_cursor_ctrl: write scoreboard fed by a behavioural model,
// table of character runs with hand-derived cursor results, plus reset/abort sequences.
module tb_term_cursor_ctrl;
    localparam int H = 240;
    localparam int V = 135;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_data = 7'h00;
    logic        bram_wen;
    logic [14:0] bram_addr;
    logic [6:0]  bram_data;
    logic [7:0]  cursor_col;
    logic [7:0]  cursor_row;
    logic [7:0]  row_offset;
    logic        busy;

    always #5 clk = ~clk;

    term_cursor_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .bram_wen   (bram_wen),
        .bram_addr  (bram_addr),
        .bram_data  (bram_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .row_offset (row_offset),
        .busy       (busy)
    );

    typedef struct {
        logic [6:0] ch;
        int         rep;
        int         col;
        int         row;
        int         off;
    } vec_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [21:0] exp_q[$];
    bit          sb_on = 1'b1;
    int          m_col = 0;
    int          m_row = 0;
    int          m_off = 0;
    vec_t        tbl[15];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb_on && !rst && bram_wen) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", {17'h1, bram_addr}, {17'h0, bram_addr});
            end else begin
                logic [21:0] e;
                e = exp_q.pop_front();
                check("wr_addr", bram_addr, e[21:7]);
                check("wr_data", bram_data, e[6:0]);
            end
        end
    end

    function automatic int maddr(input int c, input int r, input int o);
        return ((r + o) % V) * H + c;
    endfunction

    task automatic push_wr(input int a, input logic [6:0] d);
        logic [14:0] a15;
        a15 = a[14:0];
        exp_q.push_back({a15, d});
    endtask

    task automatic model_newline();
        m_col = 0;
        if (m_row < V - 1) m_row++;
        else m_off = (m_off + 1) % V;
        for (int i = 0; i < H; i++) push_wr(maddr(i, m_row, m_off), 7'h20);
    endtask

    task automatic model(input logic [6:0] c);
        if (c >= 7'h20 && c != 7'h7F) begin
            push_wr(maddr(m_col, m_row, m_off), c);
            if (m_col < H - 1) m_col++;
            else model_newline();
        end else if (c == 7'h0D) begin
            m_col = 0;
        end else if (c == 7'h0A) begin
            model_newline();
        end else if (c == 7'h08) begin
            if (m_col > 0) begin
                m_col--;
                push_wr(maddr(m_col, m_row, m_off), 7'h20);
            end
        end else if (c == 7'h0C) begin
            m_col = 0;
            m_row = 0;
            m_off = 0;
            for (int i = 0; i < H * V; i++) push_wr(i, 7'h20);
        end
    endtask

    // Valid is raised before ready is known, so it is held across any clear burst.
    task automatic send(input logic [6:0] c);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = c;
        if (sb_on) model(c);
        n = 0;
        while (!in_ready && n < 40000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", in_ready, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int n;

        tbl[0]  = '{7'h0A,   2,   0,   2, 0};
        tbl[1]  = '{7'h71,   5,   5,   2, 0};
        tbl[2]  = '{7'h08,   1,   4,   2, 0};
        tbl[3]  = '{7'h08,   4,   0,   2, 0};
        tbl[4]  = '{7'h08,   1,   0,   2, 0};
        tbl[5]  = '{7'h07,   1,   0,   2, 0};
        tbl[6]  = '{7'h6B,   3,   3,   2, 0};
        tbl[7]  = '{7'h0D,   1,   0,   2, 0};
        tbl[8]  = '{7'h0C,   1,   0,   0, 0};
        tbl[9]  = '{7'h78, 240,   0,   1, 0};
        tbl[10] = '{7'h0A, 133,   0, 134, 0};
        tbl[11] = '{7'h0A,   1,   0, 134, 1};
        tbl[12] = '{7'h79, 239, 239, 134, 1};
        tbl[13] = '{7'h79,   1,   0, 134, 2};
        tbl[14] = '{7'h7A,   1,   1, 134, 2};

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_wen", bram_wen, 0);
        check("rst_addr", bram_addr, 0);
        check("rst_data", bram_data, 0);
        check("rst_col", cursor_col, 0);
        check("rst_row", cursor_row, 0);
        check("rst_off", row_offset, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("ready_after_rst", in_ready, 1);

        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 7'h41;
        model(7'h41);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("A_wen", bram_wen, 1);
        check("A_addr", bram_addr, 0);
        check("A_data", bram_data, 7'h41);
        check("A_col", cursor_col, 1);
        check("A_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        check("A_ready_back", in_ready, 1);
        check("A_wen_single", bram_wen, 0);

        for (int v = 0; v < 15; v++) begin
            for (int r = 0; r < tbl[v].rep; r++) send(tbl[v].ch);
            wait_idle();
            check($sformatf("vec%0d_col", v), cursor_col, tbl[v].col);
            check($sformatf("vec%0d_row", v), cursor_row, tbl[v].row);
            check($sformatf("vec%0d_off", v), row_offset, tbl[v].off);
            check($sformatf("vec%0d_busy", v), busy, 0);
        end
        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        sb_on = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 7'h0C;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cnt = 0;
        n = 0;
        while (cnt < 100 && n < 1000) begin
            @(negedge clk);
            if (bram_wen) cnt++;
            n++;
        end
        check("abort_write_count", cnt, 100);
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_wen", bram_wen, 0);
        check("abort_busy", busy, 0);
        check("abort_addr", bram_addr, 0);
        check("abort_data", bram_data, 0);
        check("abort_col", cursor_col, 0);
        check("abort_row", cursor_row, 0);
        check("abort_off", row_offset, 0);
        check("abort_ready_in_rst", in_ready, 0);
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (bram_wen) cnt++;
        end
        check("abort_no_writes", cnt, 0);
        rst = 1'b0;
        @(posedge clk);
        #1 check("abort_ready_after", in_ready, 1);
        check("abort_wen_after", bram_wen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
